tlb_unit: RTL
=============

Name: tlb_unit

Overview:
- Parametrised, fully associative, MIPS-style joint TLB; successor to the fixed 64-entry write-only table.
- Adds registered translation lookup, ASID and global matching, TLBP/TLBR/TLBWR support, Random/Wired handling, and miss/invalid/modified detection.
- Sits between the CPU pipeline's address stage and the memory interface; the CP0 logic drives the entry registers.

Parameters:
- ENTRIES, 16, number of TLB entries (power of two, 4..64); IW = $clog2(ENTRIES)
- ASID_W, 8, ASID width, taken from entry_hi[ASID_W-1:0]
- PFN_W, 20, physical frame number width; PA width = PFN_W+12

Ports:
- clk  in  1  clock
- res  in  1  asynchronous active-low reset
- lk_valid  in  1  lookup request
- lk_vaddr  in  32  virtual address to translate
- lk_store  in  1  request is a store (enables the modified check)
- lk_done  out  1  lookup result valid, one cycle after the request
- lk_paddr  out  PFN_W+12  translated physical address
- lk_miss  out  1  no matching entry
- lk_invalid  out  1  matching page has V=0
- lk_modified  out  1  store to a page with D=0
- lk_cache  out  3  C field of the matched page
- entry_hi  in  32  VPN2[31:13], ASID[ASID_W-1:0]
- entry_lo0, entry_lo1  in  32  PFN[PFN_W+5:6], C[5:3], D[2], V[1], G[0]
- page_mask  in  32  mask[24:13]; used only with PAGEMASK_EN
- index_in  in  IW  entry index for indexed write/read
- wr_idx  in  1  write the entry at index_in (TLBWI)
- wr_rand  in  1  write the entry at random_out (TLBWR)
- wired_we  in  1  load wired register
- wired_in  in  IW  new wired value
- probe  in  1  TLBP: match entry_hi against all entries
- probe_done  out  1  probe result valid, one cycle after the request
- probe_miss  out  1  no match (CP0 Index.P)
- probe_index  out  IW  matching index
- rd_index  in  IW  TLBR index (combinational read)
- rd_hi, rd_lo0, rd_lo1, rd_mask  out  32  stored entry fields
- random_out  out  IW  current Random register value

Behaviour:
- Reset (res=0, async):
  - All entry valid-tags cleared, so every lookup misses.
  - random_out=ENTRIES-1, wired=0.
  - lk_done, probe_done, lk_miss, lk_invalid, lk_modified, probe_miss = 0; lk_paddr, lk_cache, probe_index = 0.
- Stored entry: VPN2, ASID, G (= lo0.G & lo1.G), PFN0/C0/D0/V0, PFN1/C1/D1/V1, mask, tag_valid. Bits 12:8 of entry_hi are zeroed on store.
- Match rule: tag_valid & VPN2 equal (bits above the mask) & (G | ASID equal to entry_hi ASID).
- Odd/even page select: vaddr bit 12 (or the bit just above the masked range with PAGEMASK_EN).
- Lookup, 1-cycle latency: request sampled at posedge N; results registered and valid in cycle N+1 with lk_done=1 for exactly one cycle. No backpressure; back-to-back requests give one result per cycle.
- Lookup outcomes, exclusive priority:
  - miss: lk_miss=1, lk_paddr=0.
  - else V=0: lk_invalid=1.
  - else store & D=0: lk_modified=1.
  - Translation succeeds only when all three flags are 0: lk_paddr = {PFN, vaddr[11:0]}.
- Multiple hits: the lowest index wins (deterministic).
- Write, 1 cycle: the entry is updated at posedge and tag_valid is set.
  - wr_idx and wr_rand asserted together: wr_idx wins.
  - A lookup or probe in the same cycle as a write sees the old contents.
- Random counter: decrements every cycle. It wraps from wired to ENTRIES-1. If random < wired it reloads ENTRIES-1.
  - wired_we: wired <= wired_in and random <= ENTRIES-1 on the same edge.
  - wr_rand uses the pre-edge random_out.
- Probe: same latency and match rule as lookup, using entry_hi VPN2/ASID. probe_done pulses for one cycle; probe_miss=1 with probe_index=0 on a miss.
- Read: rd_* are combinational from rd_index. rd_lo* G bit = the stored G.
- Reset asserted mid-lookup: pending results are dropped and lk_done=0.

Optional Feature:
- Macro: TLB_PAGEMASK_EN.
- Defined:
  - page_mask[24:13] is stored per entry, supporting 4KB..16MB pages.
  - Masked VPN bits are ignored in matching.
  - Physical address = PFN bits above the mask concatenated with vaddr bits below the page boundary.
- Undefined:
  - 4KB pages only; page_mask is ignored.
  - rd_mask reads 0; no mask storage is synthesised.

Test Plan:
- Reset then lk_vaddr=0x00400000 -> next cycle lk_done=1, lk_miss=1; random_out=ENTRIES-1.
- TLBWI index 3: hi=0x00400011, lo0=0x00001016 (PFN 0x40, D=1, V=1), lo1=0x00001052 (PFN 0x41, D=0, V=1); lookup 0x00400ABC -> paddr=0x00040ABC. Lookup 0x00401ABC with lk_store=1 -> lk_modified=1.
- Same entry, entry_hi ASID changed to 0x12, G=0 -> lk_miss=1; rewrite with G=1 in both lo -> hit.
- wired_we with wired_in=4 -> random_out=ENTRIES-1, counts down to 4 then wraps to ENTRIES-1. TLBWR -> rd_index at the sampled random shows the new entry.
- Probe for the VPN written at index 3 -> probe_done=1, probe_miss=0, probe_index=3. Probe for an unmapped VPN -> probe_miss=1.
- TLB_PAGEMASK_EN: entry with mask 0x01FFE000 (16MB) at VPN2 0x0... -> lookup 0x00ABCDEF translates with offset 0xABCDEF preserved.

Source files
------------

// File: rtl/tlb_unit.sv
// Fully associative MIPS-style joint TLB: registered lookup/probe, indexed/random write, Random/Wired.
// Optional variable page sizes are enabled by defining TLB_PAGEMASK_EN.
module tlb_unit #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ASID_W  = 8,
  parameter int unsigned PFN_W   = 20,
  localparam int unsigned IW     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                lk_valid,
  input  logic [31:0]         lk_vaddr,
  input  logic                lk_store,
  output logic                lk_done,
  output logic [PFN_W+11:0]   lk_paddr,
  output logic                lk_miss,
  output logic                lk_invalid,
  output logic                lk_modified,
  output logic [2:0]          lk_cache,
  input  logic [31:0]         entry_hi,
  input  logic [31:0]         entry_lo0,
  input  logic [31:0]         entry_lo1,
  input  logic [31:0]         page_mask,
  input  logic [IW-1:0]       index_in,
  input  logic                wr_idx,
  input  logic                wr_rand,
  input  logic                wired_we,
  input  logic [IW-1:0]       wired_in,
  input  logic                probe,
  output logic                probe_done,
  output logic                probe_miss,
  output logic [IW-1:0]       probe_index,
  input  logic [IW-1:0]       rd_index,
  output logic [31:0]         rd_hi,
  output logic [31:0]         rd_lo0,
  output logic [31:0]         rd_lo1,
  output logic [31:0]         rd_mask,
  output logic [IW-1:0]       random_out
);

  localparam int unsigned PW = PFN_W + 12;
  localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

  logic [18:0]       vpn2_q [ENTRIES];
  logic [ASID_W-1:0] asid_q [ENTRIES];
  logic [PFN_W-1:0]  pfn0_q [ENTRIES];
  logic [PFN_W-1:0]  pfn1_q [ENTRIES];
  logic [2:0]        c0_q   [ENTRIES];
  logic [2:0]        c1_q   [ENTRIES];
  logic [ENTRIES-1:0] g_q, d0_q, d1_q, v0_q, v1_q, tv_q;
`ifdef TLB_PAGEMASK_EN
  logic [11:0]       mask_q [ENTRIES];
`endif
  logic [IW-1:0]     wired_q;

  logic              wr_en;
  logic [IW-1:0]     wr_sel;
  logic              lk_hit, pr_hit;
  logic [IW-1:0]     lk_sel, pr_sel;
  logic [18:0]       ign;
  logic [ASID_W-1:0] cur_asid;

  assign wr_en    = wr_idx | wr_rand;
  assign wr_sel   = wr_idx ? index_in : random_out;
  assign cur_asid = entry_hi[ASID_W-1:0];

  // Descending scan so the lowest matching index is the one left selected.
  always_comb begin
    lk_hit = 1'b0;
    lk_sel = '0;
    pr_hit = 1'b0;
    pr_sel = '0;
    ign    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
`ifdef TLB_PAGEMASK_EN
      ign = {7'd0, mask_q[i]};
`else
      ign = '0;
`endif
      if (tv_q[i] && (((vpn2_q[i] ^ lk_vaddr[31:13]) & ~ign) == 19'd0) &&
          (g_q[i] || (asid_q[i] == cur_asid))) begin
        lk_hit = 1'b1;
        lk_sel = IW'(i);
      end
      if (tv_q[i] && (((vpn2_q[i] ^ entry_hi[31:13]) & ~ign) == 19'd0) &&
          (g_q[i] || (asid_q[i] == cur_asid))) begin
        pr_hit = 1'b1;
        pr_sel = IW'(i);
      end
    end
  end

  logic [31:0]      lk_om;
  logic             lk_odd, lk_d, lk_v, lk_ok;
  logic [PFN_W-1:0] lk_pfn;
  logic [2:0]       lk_c;
  logic [PW-1:0]    lk_pa;

  // lk_om marks the page-offset bits; the bit just above it picks the odd/even page.
  always_comb begin
`ifdef TLB_PAGEMASK_EN
    lk_om = {7'd0, mask_q[lk_sel], 13'h1fff} >> 1;
`else
    lk_om = 32'h0000_0fff;
`endif
    lk_odd = |(lk_vaddr & ((lk_om << 1) | 32'd1) & ~lk_om);
    lk_pfn = lk_odd ? pfn1_q[lk_sel] : pfn0_q[lk_sel];
    lk_c   = lk_odd ? c1_q[lk_sel]   : c0_q[lk_sel];
    lk_d   = lk_odd ? d1_q[lk_sel]   : d0_q[lk_sel];
    lk_v   = lk_odd ? v1_q[lk_sel]   : v0_q[lk_sel];
    lk_ok  = lk_hit && lk_v && !(lk_store && !lk_d);
    lk_pa  = ({lk_pfn, 12'd0} & ~PW'(lk_om)) | (PW'(lk_vaddr) & PW'(lk_om));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      lk_done     <= 1'b0;
      lk_miss     <= 1'b0;
      lk_invalid  <= 1'b0;
      lk_modified <= 1'b0;
      lk_paddr    <= '0;
      lk_cache    <= '0;
      probe_done  <= 1'b0;
      probe_miss  <= 1'b0;
      probe_index <= '0;
      random_out  <= LAST;
      wired_q     <= '0;
      tv_q        <= '0;
    end else begin
      lk_done    <= lk_valid;
      probe_done <= probe;
      if (lk_valid) begin
        lk_miss     <= !lk_hit;
        lk_invalid  <= lk_hit && !lk_v;
        lk_modified <= lk_hit && lk_v && lk_store && !lk_d;
        lk_paddr    <= lk_ok ? lk_pa : '0;
        lk_cache    <= lk_hit ? lk_c : 3'd0;
      end
      if (probe) begin
        probe_miss  <= !pr_hit;
        probe_index <= pr_hit ? pr_sel : '0;
      end
      if (wired_we) begin
        wired_q    <= wired_in;
        random_out <= LAST;
      end else if (random_out <= wired_q) begin
        random_out <= LAST;
      end else begin
        random_out <= random_out - 1'b1;
      end
      if (wr_en) tv_q[wr_sel] <= 1'b1;
    end
  end

  // Entry payload needs no reset: tv_q gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      vpn2_q[wr_sel] <= entry_hi[31:13];
      asid_q[wr_sel] <= entry_hi[ASID_W-1:0];
      g_q[wr_sel]    <= entry_lo0[0] & entry_lo1[0];
      pfn0_q[wr_sel] <= entry_lo0[PFN_W+5:6];
      c0_q[wr_sel]   <= entry_lo0[5:3];
      d0_q[wr_sel]   <= entry_lo0[2];
      v0_q[wr_sel]   <= entry_lo0[1];
      pfn1_q[wr_sel] <= entry_lo1[PFN_W+5:6];
      c1_q[wr_sel]   <= entry_lo1[5:3];
      d1_q[wr_sel]   <= entry_lo1[2];
      v1_q[wr_sel]   <= entry_lo1[1];
`ifdef TLB_PAGEMASK_EN
      mask_q[wr_sel] <= page_mask[24:13];
`endif
    end
  end

  assign rd_hi  = {vpn2_q[rd_index], 13'd0} | 32'(asid_q[rd_index]);
  assign rd_lo0 = 32'({pfn0_q[rd_index], c0_q[rd_index], d0_q[rd_index], v0_q[rd_index],
                       g_q[rd_index]});
  assign rd_lo1 = 32'({pfn1_q[rd_index], c1_q[rd_index], d1_q[rd_index], v1_q[rd_index],
                       g_q[rd_index]});

  logic unused_bits;
`ifdef TLB_PAGEMASK_EN
  assign rd_mask     = {7'd0, mask_q[rd_index], 13'd0};
  assign unused_bits = ^{entry_hi[12:ASID_W], entry_lo0[31:PFN_W+6], entry_lo1[31:PFN_W+6],
                         page_mask[31:25], page_mask[12:0]};
`else
  assign rd_mask     = 32'd0;
  assign unused_bits = ^{entry_hi[12:ASID_W], entry_lo0[31:PFN_W+6], entry_lo1[31:PFN_W+6],
                         page_mask};
`endif

endmodule
